// File: rtl/eth_tx_sched.sv
// Round-robin RGMII TX frame scheduler: preamble/SFD, payload, length guard, IFG.
// Optional minimum-length padding to 60 bytes enabled by ETH_TX_SCHED_PAD_EN.
module eth_tx_sched #(
    parameter int N         = 2,
    parameter int IFG_LEN   = 12,
    parameter int MAX_FRAME = 1518
) (
    input  logic           i_tx_clk,
    input  logic           i_tx_rst_n,
    input  logic           i_pll_locked,
    input  logic [N-1:0]   i_req,
    input  logic [8*N-1:0] i_data,
    input  logic [N-1:0]   i_last,
    output logic [N-1:0]   o_gnt,
    output logic [N-1:0]   o_rd,
    output logic [7:0]     o_tx_data,
    output logic           o_tx_en,
    output logic           o_busy,
    output logic           o_err,
    output logic [15:0]    o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
`ifdef ETH_TX_SCHED_PAD_EN
        S_PAD,
`endif
        S_IFG
    } state_t;

    // The IDLE arbitration cycle completes the gap, so IFG itself is one shorter.
    localparam int          IFG_CYC = (IFG_LEN > 1) ? IFG_LEN - 1 : 1;
    localparam logic [15:0] IFG_END = 16'(IFG_CYC - 1);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
`ifdef ETH_TX_SCHED_PAD_EN
    localparam logic [10:0] MIN_CNT = 11'd60;
`endif

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  win;
    logic [1:0]  win_c;
    logic [1:0]  ptr_c;
    logic        any_req;
    logic [2:0]  pre_cnt;
    logic [10:0] byte_cnt;
    logic [10:0] cnt_inc;
    logic [15:0] ifg_cnt;
    logic        ovr;
    logic [3:0]  req_x;
    logic [3:0]  last_x;
    logic [31:0] data_x;
    logic [7:0]  cur_byte;
    logic        cur_last;
    logic        take;
    logic        end_now;
    logic        active;
    logic        to_ifg;
    logic        err_c;
    logic        done_ok;

    always_comb begin
        req_x          = '0;
        last_x         = '0;
        data_x         = '0;
        req_x[N-1:0]   = i_req;
        last_x[N-1:0]  = i_last;
        data_x[8*N-1:0] = i_data;
    end

    always_comb begin
        any_req = 1'b0;
        win_c   = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_x[2'((int'(ptr) + i) % N)]) begin
                any_req = 1'b1;
                win_c   = 2'((int'(ptr) + i) % N);
            end
        end
        ptr_c = 2'((int'(win_c) + 1) % N);
    end

    assign cur_byte = data_x[{win, 3'b000} +: 8];
    assign cur_last = last_x[win];
    assign take     = |o_rd;
    assign cnt_inc  = byte_cnt + 11'd1;
    assign end_now  = cur_last || (cnt_inc == MAX_CNT);
    assign o_busy   = (state != S_IDLE);

`ifdef ETH_TX_SCHED_PAD_EN
    assign active = (state == S_PRE) || (state == S_DATA) || (state == S_PAD);
`else
    assign active = (state == S_PRE) || (state == S_DATA);
`endif

    always_comb begin
        to_ifg  = 1'b0;
        err_c   = 1'b0;
        done_ok = 1'b0;
        if (active && !i_pll_locked) begin
            to_ifg = 1'b1;
            err_c  = 1'b1;
        end else if (state == S_DATA && !take) begin
            if (ovr) begin
                to_ifg = 1'b1;
                err_c  = 1'b1;
            end
`ifdef ETH_TX_SCHED_PAD_EN
            else if (byte_cnt < MIN_CNT) begin
                to_ifg = 1'b0;
            end
`endif
            else begin
                to_ifg  = 1'b1;
                done_ok = 1'b1;
            end
        end
`ifdef ETH_TX_SCHED_PAD_EN
        else if (state == S_PAD && byte_cnt == MIN_CNT) begin
            to_ifg  = 1'b1;
            done_ok = 1'b1;
        end
`endif
    end

    always_ff @(posedge i_tx_clk or negedge i_tx_rst_n) begin
        if (!i_tx_rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            win         <= '0;
            pre_cnt     <= '0;
            byte_cnt    <= '0;
            ifg_cnt     <= '0;
            ovr         <= 1'b0;
            o_gnt       <= '0;
            o_rd        <= '0;
            o_tx_data   <= '0;
            o_tx_en     <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_err <= 1'b0;
            if (to_ifg) begin
                state     <= S_IFG;
                ifg_cnt   <= '0;
                o_gnt     <= '0;
                o_rd      <= '0;
                o_tx_en   <= 1'b0;
                o_tx_data <= '0;
                o_err     <= err_c;
                if (done_ok) o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_pll_locked && any_req) begin
                            state     <= S_PRE;
                            win       <= win_c;
                            ptr       <= ptr_c;
                            o_gnt     <= N'(1) << win_c;
                            pre_cnt   <= '0;
                            byte_cnt  <= '0;
                            ovr       <= 1'b0;
                            o_tx_en   <= 1'b1;
                            o_tx_data <= 8'h55;
                        end
                    end
                    S_PRE, S_DATA: begin
                        if (take) begin
                            state     <= S_DATA;
                            o_tx_data <= cur_byte;
                            byte_cnt  <= cnt_inc;
                            if (end_now) begin
                                o_rd <= '0;
                                ovr  <= !cur_last;
                            end
                        end else if (state == S_PRE) begin
                            pre_cnt <= pre_cnt + 3'd1;
                            // Eighth preamble byte is the SFD; first payload read overlaps it.
                            if (pre_cnt == 3'd6) begin
                                o_tx_data <= 8'hD5;
                                o_rd      <= o_gnt;
                            end
                        end
`ifdef ETH_TX_SCHED_PAD_EN
                        else begin
                            state     <= S_PAD;
                            o_tx_data <= 8'h00;
                            byte_cnt  <= cnt_inc;
                        end
`endif
                    end
`ifdef ETH_TX_SCHED_PAD_EN
                    S_PAD: begin
                        o_tx_data <= 8'h00;
                        byte_cnt  <= cnt_inc;
                    end
`endif
                    S_IFG: begin
                        if (ifg_cnt == IFG_END) state <= S_IDLE;
                        else ifg_cnt <= ifg_cnt + 16'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: framing, round-robin, overrun, abort, reset.
// Expected padded lengths follow ETH_TX_SCHED_PAD_EN when it is defined.
module tb_eth_tx_sched;

    localparam int N         = 2;
    localparam int IFG_LEN   = 12;
    localparam int MAX_FRAME = 1518;
    localparam int MEM_LEN   = 1600;
`ifdef ETH_TX_SCHED_PAD_EN
    localparam int SHORT_LEN = 68;
`else
    localparam int SHORT_LEN = 18;
`endif

    logic           clk;
    logic           rst_n;
    logic           locked;
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rd;
    logic [7:0]     tx_data;
    logic           tx_en;
    logic           busy;
    logic           err;
    logic [15:0]    frame_cnt;

    eth_tx_sched #(
        .N(N),
        .IFG_LEN(IFG_LEN),
        .MAX_FRAME(MAX_FRAME)
    ) dut (
        .i_tx_clk(clk),
        .i_tx_rst_n(rst_n),
        .i_pll_locked(locked),
        .i_req(req),
        .i_data(data),
        .i_last(last),
        .o_gnt(gnt),
        .o_rd(rd),
        .o_tx_data(tx_data),
        .o_tx_en(tx_en),
        .o_busy(busy),
        .o_err(err),
        .o_frame_cnt(frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [N][MEM_LEN];
    int flen [N];
    int pos [N];
    int frames_left [N];
    bit use_last [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req[k]         = frames_left[k] > 0;
            data[8*k +: 8] = mem[k][pos[k]];
            last[k]        = use_last[k] && (pos[k] == flen[k] - 1);
        end
    end

    bit         prev_en;
    int         en_run;
    int         low_run;
    int         en_total;
    int         err_cnt;
    int         bad_idle;
    int         len_q [$];
    int         gap_q [$];
    logic [N-1:0] gnt_q [$];
    logic [7:0] bytes_q [$];

    task automatic tick();
        logic [N-1:0] took;
        @(posedge clk);
        took = rd;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (took[k]) begin
                if (last[k]) begin
                    pos[k] = 0;
                    frames_left[k] = frames_left[k] - 1;
                end else begin
                    pos[k] = pos[k] + 1;
                end
            end
        end
        if (tx_en) begin
            if (!prev_en) begin
                gnt_q.push_back(gnt);
                gap_q.push_back(low_run);
                en_run = 0;
            end
            en_run++;
            en_total++;
            bytes_q.push_back(tx_data);
            low_run = 0;
        end else begin
            if (prev_en) len_q.push_back(en_run);
            low_run++;
            if (tx_data !== 8'h00) bad_idle++;
        end
        if (err) err_cnt++;
        prev_en = tx_en;
        #1;
    endtask

    task automatic clear_mon();
        len_q.delete();
        gap_q.delete();
        gnt_q.delete();
        bytes_q.delete();
        en_run   = 0;
        low_run  = 0;
        en_total = 0;
        err_cnt  = 0;
    endtask

    task automatic load(int k, int n, logic [7:0] base, bit lst, int frames);
        for (int i = 0; i < n; i++) mem[k][i] = base + 8'(i);
        flen[k]        = n;
        pos[k]         = 0;
        use_last[k]    = lst;
        frames_left[k] = frames;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            frames_left[k] = 0;
            pos[k] = 0;
        end
        tick();
        tick();
        rst_n   = 1'b1;
        prev_en = 1'b0;
    endtask

    task automatic wait_frames(int n, int budget, string name);
        int c = 0;
        while (!(len_q.size() >= n && !busy) && c < budget) begin
            tick();
            c++;
        end
        tests++;
        if (c >= budget) begin
            fails++;
            $display("FAIL %s_timeout: got %0d frames expected %0d", name, len_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests++;
        if ({gnt, rd, tx_data, tx_en, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_outs: got %0h expected 0", {gnt, rd, tx_data, tx_en, busy, err});
        end
        tests++;
        if (frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d expected 0", frame_cnt);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (busy !== 1'b0 || tx_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%0b en=%0b expected 0 0", busy, tx_en);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [12];
        for (int i = 0; i < 7; i++) exp[i] = 8'h55;
        exp[7]  = 8'hD5;
        exp[8]  = 8'h11;
        exp[9]  = 8'h22;
        exp[10] = 8'h33;
        exp[11] = 8'h44;
        clear_mon();
        mem[0][0] = 8'h11;
        mem[0][1] = 8'h22;
        mem[0][2] = 8'h33;
        mem[0][3] = 8'h44;
        flen[0] = 4;
        pos[0] = 0;
        use_last[0] = 1'b1;
        frames_left[0] = 1;
        wait_frames(1, 100, "single");
        tests++;
        if (len_q[0] !== 12) begin
            fails++;
            $display("FAIL single_len: got %0d expected 12", len_q[0]);
        end
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (bytes_q[i] !== exp[i]) begin
                fails++;
                $display("FAIL single_byte%0d: got %0h expected %0h", i, bytes_q[i], exp[i]);
            end
        end
        tests++;
        if (gnt_q[0] !== 2'b01) begin
            fails++;
            $display("FAIL single_gnt: got %0b expected 01", gnt_q[0]);
        end
        tests++;
        if (low_run !== IFG_LEN) begin
            fails++;
            $display("FAIL single_ifg: got %0d expected %0d", low_run, IFG_LEN);
        end
        tests++;
        if (frame_cnt !== 16'd1) begin
            fails++;
            $display("FAIL single_cnt: got %0d expected 1", frame_cnt);
        end
        tests++;
        if (err_cnt !== 0) begin
            fails++;
            $display("FAIL single_err: got %0d expected 0", err_cnt);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_mon();
        load(0, 4, 8'hA0, 1'b1, 2);
        load(1, 4, 8'hB0, 1'b1, 2);
        wait_frames(4, 400, "rr");
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] eg;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests++;
            if (gnt_q[i] !== eg) begin
                fails++;
                $display("FAIL rr_gnt%0d: got %0b expected %0b", i, gnt_q[i], eg);
            end
            tests++;
            if (len_q[i] !== 12) begin
                fails++;
                $display("FAIL rr_len%0d: got %0d expected 12", i, len_q[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            tests++;
            if (gap_q[i] !== IFG_LEN) begin
                fails++;
                $display("FAIL rr_gap%0d: got %0d expected %0d", i, gap_q[i], IFG_LEN);
            end
        end
        tests++;
        if (bytes_q[20] !== 8'hB0 || bytes_q[23] !== 8'hB3) begin
            fails++;
            $display("FAIL rr_payload: got %0h %0h expected b0 b3", bytes_q[20], bytes_q[23]);
        end
        tests++;
        if (frame_cnt !== 16'd4) begin
            fails++;
            $display("FAIL rr_cnt: got %0d expected 4", frame_cnt);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] fc0;
        int c = 0;
        fc0 = frame_cnt;
        clear_mon();
        load(0, MEM_LEN, 8'h00, 1'b0, 1);
        while (!(len_q.size() >= 1 && !busy) && c < 3000) begin
            tick();
            if (err) frames_left[0] = 0;
            c++;
        end
        tests++;
        if (c >= 3000) begin
            fails++;
            $display("FAIL ovr_timeout: got %0d frames expected 1", len_q.size());
        end
        tests++;
        if (len_q[0] !== 8 + MAX_FRAME) begin
            fails++;
            $display("FAIL ovr_len: got %0d expected %0d", len_q[0], 8 + MAX_FRAME);
        end
        tests++;
        if (pos[0] !== MAX_FRAME) begin
            fails++;
            $display("FAIL ovr_reads: got %0d expected %0d", pos[0], MAX_FRAME);
        end
        tests++;
        if (bytes_q[8 + MAX_FRAME - 1] !== 8'hED) begin
            fails++;
            $display("FAIL ovr_lastbyte: got %0h expected ed", bytes_q[8 + MAX_FRAME - 1]);
        end
        tests++;
        if (err_cnt !== 1) begin
            fails++;
            $display("FAIL ovr_err: got %0d expected 1", err_cnt);
        end
        tests++;
        if (frame_cnt !== fc0) begin
            fails++;
            $display("FAIL ovr_cnt: got %0d expected %0d", frame_cnt, fc0);
        end
    endtask

    task automatic test_abort();
        logic [15:0] fc0;
        logic [N-1:0] gseen;
        int c = 0;
        fc0 = frame_cnt;
        clear_mon();
        load(0, 10, 8'h61, 1'b1, 1);
        while (!(tx_en && tx_data == 8'h63) && c < 60) begin
            tick();
            c++;
        end
        tests++;
        if (c >= 60) begin
            fails++;
            $display("FAIL abort_start_timeout: got %0h expected 63", tx_data);
        end
        locked = 1'b0;
        tick();
        tests++;
        if (tx_en !== 1'b0 || err !== 1'b1 || rd !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_next: got en=%0b err=%0b rd=%0b busy=%0b expected 0 1 0 1",
                     tx_en, err, rd, busy);
        end
        pos[0] = 0;
        gseen = '0;
        repeat (40) begin
            tick();
            gseen |= gnt;
        end
        tests++;
        if (gseen !== '0 || len_q.size() !== 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_hold: got gnt=%0b frames=%0d busy=%0b expected 0 1 0",
                     gseen, len_q.size(), busy);
        end
        tests++;
        if (len_q[0] !== 11) begin
            fails++;
            $display("FAIL abort_len: got %0d expected 11", len_q[0]);
        end
        locked = 1'b1;
        wait_frames(2, 200, "abort_resume");
        tests++;
        if (len_q[1] !== SHORT_LEN) begin
            fails++;
            $display("FAIL abort_resume_len: got %0d expected %0d", len_q[1], SHORT_LEN);
        end
        tests++;
        if (err_cnt !== 1 || frame_cnt !== fc0 + 16'd1) begin
            fails++;
            $display("FAIL abort_counts: got err=%0d cnt=%0d expected 1 %0d",
                     err_cnt, frame_cnt, fc0 + 16'd1);
        end
    endtask

    task automatic test_short_frame();
        logic [15:0] fc0;
        fc0 = frame_cnt;
        clear_mon();
        load(0, 10, 8'h30, 1'b1, 1);
        wait_frames(1, 200, "short");
        tests++;
        if (len_q[0] !== SHORT_LEN) begin
            fails++;
            $display("FAIL short_len: got %0d expected %0d", len_q[0], SHORT_LEN);
        end
        tests++;
        if (bytes_q[17] !== 8'h39) begin
            fails++;
            $display("FAIL short_lastbyte: got %0h expected 39", bytes_q[17]);
        end
`ifdef ETH_TX_SCHED_PAD_EN
        tests++;
        if (bytes_q[18] !== 8'h00 || bytes_q[67] !== 8'h00) begin
            fails++;
            $display("FAIL short_pad: got %0h %0h expected 0 0", bytes_q[18], bytes_q[67]);
        end
`endif
        tests++;
        if (frame_cnt !== fc0 + 16'd1 || err_cnt !== 0) begin
            fails++;
            $display("FAIL short_counts: got cnt=%0d err=%0d expected %0d 0",
                     frame_cnt, err_cnt, fc0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c = 0;
        load(1, 20, 8'h80, 1'b1, 1);
        while (!(tx_en && tx_data == 8'h82) && c < 80) begin
            tick();
            c++;
        end
        tests++;
        if (c >= 80) begin
            fails++;
            $display("FAIL rstmid_start_timeout: got %0h expected 82", tx_data);
        end
        rst_n = 1'b0;
        frames_left[1] = 0;
        #1;
        tests++;
        if ({gnt, rd, tx_data, tx_en, busy, err} !== '0 || frame_cnt !== 16'd0) begin
            fails++;
            $display("FAIL rstmid_async: got %0h cnt=%0d expected 0 0",
                     {gnt, rd, tx_data, tx_en, busy, err}, frame_cnt);
        end
        pos[1] = 0;
        tick();
        tick();
        rst_n   = 1'b1;
        prev_en = 1'b0;
        clear_mon();
        repeat (30) tick();
        tests++;
        if (en_total !== 0 || busy !== 1'b0 || gnt !== '0) begin
            fails++;
            $display("FAIL rstmid_idle: got en=%0d busy=%0b gnt=%0b expected 0 0 0",
                     en_total, busy, gnt);
        end
    endtask

    task automatic test_idle_data();
        tests++;
        if (bad_idle !== 0) begin
            fails++;
            $display("FAIL idle_data: got %0d nonzero idle bytes expected 0", bad_idle);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        locked   = 1'b1;
        prev_en  = 1'b0;
        bad_idle = 0;
        for (int k = 0; k < N; k++) begin
            flen[k] = 1;
            pos[k] = 0;
            frames_left[k] = 0;
            use_last[k] = 1'b0;
            for (int i = 0; i < MEM_LEN; i++) mem[k][i] = 8'h00;
        end
        clear_mon();
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_abort();
        test_short_frame();
        test_reset_mid_frame();
        test_idle_data();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit-side frame scheduler for the RGMII Ethernet path, in the `i_tx_clk` (PLL 90°) domain.
- Arbitrates N byte-stream requesters (e.g. command reply, data stream) round-robin onto the single 8-bit TX datapath that feeds the DDR output stage.
- Sequences each frame: preamble/SFD insertion, payload pass-through, length guard, then enforced inter-frame gap.
- Holds the line idle while the PLL is unlocked.

Parameters:
- `N`, 2, number of requesters (1..4).
- `IFG_LEN`, 12, inter-frame gap in byte cycles (≥1).
- `MAX_FRAME`, 1518, maximum payload bytes per frame before forced termination (≤2047).

Ports:
- `i_tx_clk`  in  1  TX byte clock; all logic on its rising edge.
- `i_tx_rst_n`  in  1  asynchronous active-low reset.
- `i_pll_locked`  in  1  PLL lock; 0 blocks new frames and aborts an active one.
- `i_req`  in  N  per-requester frame-pending request; level, held until granted frame ends.
- `i_data`  in  8*N  per-requester current byte; requester k on bits [8k+7:8k].
- `i_last`  in  N  marks current byte of requester k as final payload byte.
- `o_gnt`  out  N  one-hot grant, held from preamble start to end of frame.
- `o_rd`  out  N  byte-consume strobe to granted requester; byte on `i_data` is taken at this edge.
- `o_tx_data`  out  8  byte to eth_out (registered).
- `o_tx_en`  out  1  transmit enable to eth_out (registered).
- `o_busy`  out  1  high in any state other than IDLE.
- `o_err`  out  1  one-cycle pulse on abort or length overrun.
- `o_frame_cnt`  out  16  count of frames completed without error, wraps at 0xFFFF→0.

Behaviour:
- Reset (async, `i_tx_rst_n`=0): state IDLE; all outputs 0; round-robin pointer = 0 (requester 0 highest priority).
- States: IDLE, PRE, DATA, PAD (option only), IFG.
- IDLE: if `i_pll_locked`=1 and any `i_req`, select the first requesting index at or after the pointer (circular). Next cycle: PRE, `o_gnt` one-hot, pointer = winner+1 mod N.
- PRE: 8 cycles. `o_tx_en`=1. `o_tx_data`=0x55 for cycles 1–7 and 0xD5 for cycle 8. `o_rd`[winner]=1 during cycle 8.
- DATA: `o_rd`[winner]=1 every cycle until the byte with `i_last`=1 is consumed. Each consumed byte appears on `o_tx_data` the following cycle with `o_tx_en`=1.
  - No stalls: the requester must present a valid byte whenever `o_rd`=1.
  - 11-bit byte counter is cleared on entering PRE and incremented per consumed byte.
- Normal end: after the last byte is output, go to IFG (or PAD, see option). Increment `o_frame_cnt`.
- Overrun: the counter reaching `MAX_FRAME` with no `i_last` forces termination after byte `MAX_FRAME`. Then IFG, `o_err` pulse, no count increment.
- Abort: `i_pll_locked`=0 in PRE/DATA/PAD gives, next cycle, `o_tx_en`=0, `o_rd`=0, state IFG, `o_err` pulse.
- IFG: `o_gnt`=0, `o_rd`=0, `o_tx_en`=0, `o_tx_data`=0x00 for exactly `IFG_LEN` cycles, then IDLE. Requests are not sampled during IFG.
- `i_req` dropped by the granted requester mid-frame is ignored; framing is driven only by `i_last`/overrun/abort.
- Simultaneous `i_last` and `MAX_FRAME` reached: treat as normal end, no error.
- `o_tx_data`=0x00 whenever `o_tx_en`=0.
- Back-to-back frames from the same requester are allowed when it is the only one requesting.

Optional Feature:
- Macro: `ETH_TX_SCHED_PAD_EN`.
- Defined: if a frame ends with fewer than 60 payload bytes, enter PAD after the last byte. PAD emits 0x00 with `o_tx_en`=1 until 60 bytes total are sent, then IFG. `o_rd`=0 in PAD.
- Not defined: PAD state and logic absent; short frames go directly to IFG.

Test Plan:
1. Reset mid-frame (assert `i_tx_rst_n`=0 in DATA) -> all outputs 0 immediately; with `i_req`=0 the block stays IDLE after release.
2. Single requester 0, 4-byte frame 0x11,0x22,0x33,0x44 -> `o_tx_en` high 12 cycles: 7×0x55, 0xD5, 0x11..0x44. Then 12 idle cycles, `o_frame_cnt`=1, `o_err` never high.
3. Both requesters hold `i_req` for 4 frames -> grants alternate 0,1,0,1. Exactly 12 `o_tx_en`-low cycles between frames.
4. Requester streams 1600 bytes, no `i_last` -> exactly 1518 payload bytes sent, `o_err` one pulse, `o_frame_cnt` unchanged.
5. `i_pll_locked` driven 0 on 3rd payload byte -> `o_tx_en` low next cycle, `o_err` pulse, IFG observed. No new grant until lock returns.
6. With `ETH_TX_SCHED_PAD_EN`, 10-byte frame -> 10 payload bytes plus 50×0x00, `o_tx_en` high 68 cycles. Without the macro -> 18 cycles.
